alu_spi_slave: RTL and testbench

Serial ALU endpoint on the far side of the processor's SPI link; the processor drives the link as master.
- Receives an operation packet {operand_b, operand_a, alu_op} (alu_op in the LSBs), bit 0 first, after a start bit.
- Evaluates the operation and returns a REGISTER_SIZE-bit result, bit 0 first, after its own start bit.
- Single clock domain: spi.sclk is tied to i_clock by the master; the block uses only i_clock.

---
 rtl/alu_spi_slave_pkg.sv | 29 ++
 rtl/spi_if.sv | 14 +
 rtl/alu_spi_slave_alu_core.sv | 45 ++++
 rtl/alu_spi_slave.sv | 143 ++++++++++++++
 tb/tb_alu_spi_slave.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_spi_slave_pkg.sv
// Isa: shared definitions for the serial ALU endpoint.
// Holds the register width, the ALU opcode encodings, the packed operation
// packet layout {b, a, op} (op in the LSBs) and the packet width.
package Isa;

  localparam int REGISTER_SIZE = 8;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    SLT = 3'd7
  } AluOperation;

  localparam int OP_WIDTH = $bits(AluOperation);

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] b;
    logic [REGISTER_SIZE-1:0] a;
    AluOperation              op;
  } AluPacket;

  localparam int ALU_PACKET_WIDTH = 2 * REGISTER_SIZE + OP_WIDTH;

endpackage

// File: rtl/spi_if.sv
// Spi: single-clock SPI link bundle.
// sclk  - serial clock (tied to the system clock by the master)
// nss   - slave select, active low
// mosi  - master-to-slave data
// miso  - slave-to-master data
interface Spi;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport SlaveSpi (input sclk, input nss, input mosi, output miso);
  modport MasterSpi (output sclk, output nss, output mosi, input miso);
endinterface

// File: rtl/alu_spi_slave_alu_core.sv
// alu_core: purely combinational ALU, (op, a, b) -> result.
// Ports:
//   op     in  OP_WIDTH       operation code (Isa::AluOperation encoding)
//   a      in  REGISTER_SIZE  first operand
//   b      in  REGISTER_SIZE  second operand / shift amount source
//   result out REGISTER_SIZE  operation result, no flags or carry
module alu_core
  import Isa::*;
#(
  parameter int REGISTER_SIZE = Isa::REGISTER_SIZE,
  parameter int OP_WIDTH      = Isa::OP_WIDTH
) (
  input  logic [OP_WIDTH-1:0]      op,
  input  logic [REGISTER_SIZE-1:0] a,
  input  logic [REGISTER_SIZE-1:0] b,
  output logic [REGISTER_SIZE-1:0] result
);

  localparam int SH_W = $clog2(REGISTER_SIZE);

  logic signed [REGISTER_SIZE-1:0] a_s;
  logic signed [REGISTER_SIZE-1:0] b_s;
  logic        [SH_W-1:0]          shamt;

  assign a_s   = a;
  assign b_s   = b;
  // Only the low bits of b select the shift; larger amounts alias.
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      SLL:     result = a << shamt;
      SRL:     result = a >> shamt;
      SLT:     result = {{(REGISTER_SIZE-1){1'b0}}, (a_s < b_s)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_spi_slave.sv
// alu_spi_slave: serial ALU endpoint on the slave side of an SPI link.
// Receives {b, a, op} bit 0 first after a start bit, computes the result,
// then returns it bit 0 first after its own start bit.
// Ports:
//   i_clock  in   system clock, all state updates on posedge
//   i_reset  in   asynchronous active-high reset
//   spi      Spi.SlaveSpi (sclk unused, nss active low, mosi in, miso out)
//   o_busy   out  high whenever not idle
//   o_result out  last computed result, held until the next compute
module alu_spi_slave
  import Isa::*;
#(
  parameter int REGISTER_SIZE = Isa::REGISTER_SIZE,
  parameter int OP_WIDTH      = Isa::OP_WIDTH
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  Spi.SlaveSpi                     spi,
  output logic                     o_busy,
  output logic [REGISTER_SIZE-1:0] o_result
);

  localparam int N     = 2 * REGISTER_SIZE + OP_WIDTH;
  localparam int CNT_W = $clog2(N);
  localparam int SEL_W = $clog2(REGISTER_SIZE);

  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(REGISTER_SIZE - 1);

  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    RECEIVING  = 5'b00010,
    COMPUTE    = 5'b00100,
    SEND_START = 5'b01000,
    SENDING    = 5'b10000
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic [N-1:0]             shift_in;
  logic                     rx_we;
  logic                     res_we;
  logic                     miso;
  logic [REGISTER_SIZE-1:0] alu_result;
  logic                     unused_sclk;

  assign unused_sclk = spi.sclk;

  alu_core #(
    .REGISTER_SIZE (REGISTER_SIZE),
    .OP_WIDTH      (OP_WIDTH)
  ) u_alu_core (
    .op     (shift_in[OP_WIDTH-1:0]),
    .a      (shift_in[OP_WIDTH +: REGISTER_SIZE]),
    .b      (shift_in[OP_WIDTH+REGISTER_SIZE +: REGISTER_SIZE]),
    .result (alu_result)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rx_we      = 1'b0;
    res_we     = 1'b0;
    // Deselect abandons any frame in flight and wins over every transition.
    if (state != IDLE && spi.nss) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!spi.nss && spi.mosi) begin
            state_next = RECEIVING;
            cnt_next   = '0;
          end
        end
        RECEIVING: begin
          rx_we = 1'b1;
          if (cnt == LAST_RX) begin
            state_next = COMPUTE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        COMPUTE: begin
          res_we     = 1'b1;
          state_next = SEND_START;
        end
        SEND_START: begin
          state_next = SENDING;
          cnt_next   = '0;
        end
        SENDING: begin
          if (cnt == LAST_TX) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // miso depends on state only; it must be 0 outside the reply so the
  // master can leave its own start state.
  always_comb begin
    miso = 1'b0;
    case (state)
      SEND_START: miso = 1'b1;
      SENDING:    miso = o_result[cnt[SEL_W-1:0]];
      default:    miso = 1'b0;
    endcase
  end

  assign spi.miso = miso;
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shift_in <= '0;
      o_result <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (rx_we) begin
        shift_in[cnt] <= spi.mosi;
      end
      if (res_we) begin
        o_result <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_spi_slave.sv
module tb_alu_spi_slave;
  import Isa::*;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] result;
  int         checks;
  int         errors;

  Spi bus ();

  assign bus.sclk = clk;

  alu_spi_slave dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .spi      (bus),
    .o_busy   (busy),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic AluPacket mk(input AluOperation op, input logic [7:0] a, input logic [7:0] b);
    AluPacket p;
    p.op = op;
    p.a  = a;
    p.b  = b;
    return p;
  endfunction

  // Drives the start bit (unless already driven) and the 19 packet bits.
  task automatic send_packet(input AluPacket p, input bit start_driven);
    logic [ALU_PACKET_WIDTH-1:0] bits;
    bits = p;
    if (!start_driven) begin
      @(negedge clk);
      bus.nss  = 1'b0;
      bus.mosi = 1'b1;
    end
    for (int i = 0; i < ALU_PACKET_WIDTH; i++) begin
      @(negedge clk);
      bus.mosi = bits[i];
    end
  endtask

  // Follows the reply: COMPUTE cycle, start bit, 8 result bits, then idle.
  task automatic get_reply(input string tag, input logic [7:0] exp, input bit chain);
    logic [7:0] got;
    got = '0;
    @(negedge clk);
    bus.mosi = 1'b0;
    check({tag, "_compute_miso"}, 32'(bus.miso), 32'd0);
    check({tag, "_compute_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_start_bit"}, 32'(bus.miso), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got[i] = bus.miso;
    end
    check({tag, "_busy_last_bit"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_serial"}, 32'(got), 32'(exp));
    check({tag, "_result"}, 32'(result), 32'(exp));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_miso_done"}, 32'(bus.miso), 32'd0);
    if (chain) bus.mosi = 1'b1;
  endtask

  task automatic frame(input string tag, input AluPacket p, input logic [7:0] exp,
                       input bit start_driven, input bit chain);
    send_packet(p, start_driven);
    get_reply(tag, exp, chain);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.nss  = 1'b1;
    bus.mosi = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // mosi high while deselected must not start a frame
    bus.mosi = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("nss_high_busy", 32'(busy), 32'd0);
    bus.mosi = 1'b0;

    frame("add", mk(ADD, 8'h05, 8'h03), 8'h08, 1'b0, 1'b0);
    frame("sub", mk(SUB, 8'h03, 8'h05), 8'hFE, 1'b0, 1'b0);
    frame("slt", mk(SLT, 8'h80, 8'h01), 8'h01, 1'b0, 1'b0);
    frame("srl", mk(SRL, 8'h81, 8'h09), 8'h40, 1'b0, 1'b0);
    frame("sll", mk(SLL, 8'h03, 8'h02), 8'h0C, 1'b0, 1'b0);
    frame("add_wrap", mk(ADD, 8'hFF, 8'h01), 8'h00, 1'b0, 1'b0);

    // idle guard: selected but no start bit
    bus.nss  = 1'b0;
    bus.mosi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_miso", 32'(bus.miso), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // abort after packet bit 7
    begin
      logic [ALU_PACKET_WIDTH-1:0] bits;
      bits = mk(ADD, 8'hAA, 8'h55);
      @(negedge clk);
      bus.mosi = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        bus.mosi = bits[i];
      end
      @(negedge clk);
      check("abort_pre_busy", 32'(busy), 32'd1);
      bus.nss = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_miso", 32'(bus.miso), 32'd0);
      check("abort_keep_result", 32'(result), 32'h00);
      bus.nss  = 1'b0;
      bus.mosi = 1'b0;
    end
    frame("after_abort", mk(ADD, 8'h01, 8'h01), 8'h02, 1'b0, 1'b0);

    // asynchronous reset in the middle of the reply
    send_packet(mk(ADD, 8'h05, 8'h03), 1'b0);
    @(negedge clk);
    bus.mosi = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("pre_rst_result", 32'(result), 32'h08);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_miso", 32'(bus.miso), 32'd0);
    check("async_rst_result", 32'(result), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    frame("xor", mk(XOR, 8'hF0, 8'hFF), 8'h0F, 1'b0, 1'b0);

    // back-to-back frames, second start bit on the first idle cycle
    frame("and_b2b", mk(AND, 8'hCC, 8'hAA), 8'h88, 1'b0, 1'b1);
    frame("or_b2b", mk(OR, 8'hCC, 8'hAA), 8'hEE, 1'b1, 1'b0);

    bus.nss = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
